// File: rtl/aes_round_ctrl_if.sv
// Load/done and round-control bundle between the AES sequencer and the SPI shifter / round datapath.
// master = sequencer side, slave = datapath/SPI side.
interface aes_round_ctrl_if;
    logic       load;
    logic       init_sel;
    logic       key_init;
    logic       key_step;
    logic       state_we;
    logic       mix_en;
    logic [3:0] round;
    logic [7:0] rcon;
    logic       busy;
    logic       done;

    modport master (
        input  load,
        output init_sel, key_init, key_step, state_we, mix_en, round, rcon, busy, done
    );

    modport slave (
        output load,
        input  init_sel, key_init, key_step, state_we, mix_en, round, rcon, busy, done
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: load falling edge -> INIT, NR rounds of ROUND_CYCLES clocks, then DONE.
// Optional macro LOAD_SYNC_EN adds a 2-flop synchronizer on load ahead of the edge detector.
module aes_round_ctrl #(
    parameter int NR           = 10,
    parameter int ROUND_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    aes_round_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(ROUND_CYCLES - 1);
    localparam logic [3:0] NR_L     = 4'(NR);

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
    endfunction

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [3:0] round_r, round_nxt;
    logic [7:0] rcon_r, rcon_nxt;
    logic       load_s;
    logic       load_q;
    logic       start;
    logic       abort;
    logic       step_nxt;

    logic init_sel_r, key_init_r, key_step_r, state_we_r, mix_en_r, busy_r, done_r;

`ifdef LOAD_SYNC_EN
    logic load_m1, load_m2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_m1 <= 1'b0;
            load_m2 <= 1'b0;
        end else begin
            load_m1 <= bus.load;
            load_m2 <= load_m1;
        end
    end

    assign load_s = load_m2;
`else
    assign load_s = bus.load;
`endif

    // load_q clears on reset, so a load held high across reset release yields no start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) load_q <= 1'b0;
        else          load_q <= load_s;
    end

    assign start = load_q & ~load_s;
    assign abort = load_s && (state == INIT || state == ROUND || state == FINAL);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        round_nxt = round_r;
        rcon_nxt  = rcon_r;
        case (state)
            IDLE: begin
                cnt_nxt   = '0;
                round_nxt = '0;
                rcon_nxt  = 8'h01;
                if (start) state_nxt = INIT;
            end
            INIT: begin
                state_nxt = ROUND;
                cnt_nxt   = '0;
                round_nxt = 4'd1;
                rcon_nxt  = 8'h01;
            end
            ROUND: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    round_nxt = round_r + 4'd1;
                    rcon_nxt  = xtime(rcon_r);
                    if (round_r + 4'd1 == NR_L) state_nxt = FINAL;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            FINAL: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            DONE: begin
                if (load_s) begin
                    state_nxt = IDLE;
                    round_nxt = '0;
                    rcon_nxt  = 8'h01;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            round_nxt = '0;
            rcon_nxt  = 8'h01;
        end
    end

    // Outputs are decoded from the next state and registered, so they are clean flop outputs
    assign step_nxt = (state_nxt == ROUND || state_nxt == FINAL) && (cnt_nxt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            round_r    <= '0;
            rcon_r     <= 8'h01;
            init_sel_r <= 1'b0;
            key_init_r <= 1'b0;
            key_step_r <= 1'b0;
            state_we_r <= 1'b0;
            mix_en_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            round_r    <= round_nxt;
            rcon_r     <= rcon_nxt;
            init_sel_r <= (state_nxt == INIT);
            key_init_r <= (state_nxt == INIT);
            key_step_r <= step_nxt;
            state_we_r <= (state_nxt == INIT) || step_nxt;
            mix_en_r   <= (state_nxt == ROUND);
            busy_r     <= (state_nxt == INIT) || (state_nxt == ROUND) || (state_nxt == FINAL);
            done_r     <= (state_nxt == DONE);
        end
    end

    assign bus.init_sel = init_sel_r;
    assign bus.key_init = key_init_r;
    assign bus.key_step = key_step_r;
    assign bus.state_we = state_we_r;
    assign bus.mix_en   = mix_en_r;
    assign bus.round    = round_r;
    assign bus.rcon     = rcon_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: reset, nominal timeline, rcon sequence, abort, done hold and
// a ROUND_CYCLES=1 instance. Cycle offsets j count from the cycle the DUT itself sees load fall.
module tb_aes_round_ctrl;

`ifdef LOAD_SYNC_EN
    localparam int SYNC_D = 2;
`else
    localparam int SYNC_D = 0;
`endif

    logic clk;
    logic reset_n;
    int   n_chk;
    int   n_fail;

    aes_round_ctrl_if bus0 ();
    aes_round_ctrl_if bus1 ();

    aes_round_ctrl #(.NR(10), .ROUND_CYCLES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    aes_round_ctrl #(.NR(10), .ROUND_CYCLES(1)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drops load on bus0 and checks every control output over the full 2-cycle-per-round timeline
    task automatic nominal_run();
        logic [7:0] rc_tab [10];
        int steps;
        int ks_seen;
        int j;
        logic e_we, e_ks, e_mix, e_busy, e_done, e_init;
        rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
        steps   = 0;
        ks_seen = 0;
        bus0.load = 1'b0;
        for (int i = 1; i <= 24 + SYNC_D; i++) begin
            tick();
            j      = i - SYNC_D;
            e_init = (j == 1);
            e_ks   = (j >= 3) && (j <= 21) && (j % 2 == 1);
            e_we   = e_init || e_ks;
            e_mix  = (j >= 2) && (j <= 19);
            e_busy = (j >= 1) && (j <= 21);
            e_done = (j >= 22);
            chk($sformatf("init_sel j=%0d", j), 32'(bus0.init_sel), 32'(e_init));
            chk($sformatf("key_init j=%0d", j), 32'(bus0.key_init), 32'(e_init));
            chk($sformatf("state_we j=%0d", j), 32'(bus0.state_we), 32'(e_we));
            chk($sformatf("key_step j=%0d", j), 32'(bus0.key_step), 32'(e_ks));
            chk($sformatf("mix_en j=%0d", j),   32'(bus0.mix_en),   32'(e_mix));
            chk($sformatf("busy j=%0d", j),     32'(bus0.busy),     32'(e_busy));
            chk($sformatf("done j=%0d", j),     32'(bus0.done),     32'(e_done));
            if (j == 1) chk("init round", 32'(bus0.round), 32'd0);
            if (bus0.key_step === 1'b1) ks_seen++;
            if (e_ks && steps < 10) begin
                chk($sformatf("rcon step%0d", steps + 1),  32'(bus0.rcon),  32'(rc_tab[steps]));
                chk($sformatf("round step%0d", steps + 1), 32'(bus0.round), steps + 1);
                steps++;
            end
        end
        chk("key_step count", ks_seen, 32'd10);
        chk("done round", 32'(bus0.round), 32'd10);
    endtask

    initial begin
        int j;
        int ks1;
        n_chk     = 0;
        n_fail    = 0;
        reset_n   = 1'b1;
        bus0.load = 1'b1;
        bus1.load = 1'b1;

        // Reset asserted with load high
        #1 reset_n = 1'b0;
        #1;
        chk("rst busy",     32'(bus0.busy),     32'd0);
        chk("rst done",     32'(bus0.done),     32'd0);
        chk("rst state_we", 32'(bus0.state_we), 32'd0);
        chk("rst init_sel", 32'(bus0.init_sel), 32'd0);
        chk("rst mix_en",   32'(bus0.mix_en),   32'd0);
        chk("rst round",    32'(bus0.round),    32'd0);
        chk("rst rcon",     32'(bus0.rcon),     32'h01);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("hold busy",     32'(bus0.busy),     32'd0);
            chk("hold state_we", 32'(bus0.state_we), 32'd0);
            chk("hold init_sel", 32'(bus0.init_sel), 32'd0);
            chk("hold done",     32'(bus0.done),     32'd0);
            chk("hold1 busy",    32'(bus1.busy),     32'd0);
        end

        // Nominal encryption
        nominal_run();

        // Done holds with load low
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("done hold", 32'(bus0.done), 32'd1);
        end

        // Rearm: done drops one cycle after the DUT sees load high
        bus0.load = 1'b1;
        for (int i = 1; i <= SYNC_D; i++) begin
            tick();
            chk("done pre-clear", 32'(bus0.done), 32'd1);
        end
        tick();
        chk("done clear", 32'(bus0.done),  32'd0);
        chk("clear round", 32'(bus0.round), 32'd0);
        chk("clear rcon",  32'(bus0.rcon),  32'h01);
        for (int i = 0; i < 3; i++) tick();

        // Abort: load raised during round 4's last cycle
        bus0.load = 1'b0;
        for (int i = 1; i <= 30 + SYNC_D; i++) begin
            tick();
            j = i - SYNC_D;
            if (j == 9) chk("abort we j=9", 32'(bus0.state_we), 32'd1);
            if (j >= 10) begin
                chk($sformatf("abort we j=%0d", j), 32'(bus0.state_we), 32'd0);
                chk($sformatf("abort ks j=%0d", j), 32'(bus0.key_step), 32'd0);
                chk($sformatf("abort busy j=%0d", j), 32'(bus0.busy), 32'd0);
            end
            chk($sformatf("abort done j=%0d", j), 32'(bus0.done), 32'd0);
            if (i == 9) bus0.load = 1'b1;
        end
        chk("abort round", 32'(bus0.round), 32'd0);
        chk("abort rcon",  32'(bus0.rcon),  32'h01);

        // Fresh falling edge after abort runs the complete sequence
        nominal_run();

        // ROUND_CYCLES=1 instance: done 12 cycles after start
        ks1 = 0;
        bus1.load = 1'b0;
        for (int i = 1; i <= 14 + SYNC_D; i++) begin
            tick();
            j = i - SYNC_D;
            chk($sformatf("rc1 we j=%0d", j),   32'(bus1.state_we), 32'((j >= 1) && (j <= 11)));
            chk($sformatf("rc1 ks j=%0d", j),   32'(bus1.key_step), 32'((j >= 2) && (j <= 11)));
            chk($sformatf("rc1 mix j=%0d", j),  32'(bus1.mix_en),   32'((j >= 2) && (j <= 10)));
            chk($sformatf("rc1 done j=%0d", j), 32'(bus1.done),     32'(j >= 12));
            if (bus1.key_step === 1'b1) ks1++;
            if (j == 11) chk("rc1 final rcon", 32'(bus1.rcon), 32'h36);
        end
        chk("rc1 key_step count", ks1, 32'd10);
        chk("rc1 done round", 32'(bus1.round), 32'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
